// File: rtl/lisnoc_dma_initiator_nocpkt_pkg.sv
// rtl/lisnoc_dma_initiator_nocpkt_pkg.sv - shared field widths, codes and header packing for the DMA NoC packetizer
package lisnoc_dma_initiator_nocpkt_pkg;

   // Request size field minus the two byte-offset bits: length counted in words
   localparam int REQ_SIZE_W = 30;

   // Flit type codes carried in flit[33:32]
   localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
   localparam logic [1:0] FLIT_HEADER  = 2'b01;
   localparam logic [1:0] FLIT_LAST    = 2'b10;

   // Header class and kind codes
   localparam logic [2:0] CLASS_DMA = 3'b010;
   localparam logic [1:0] KIND_L2R  = 2'b00;
   localparam logic [1:0] KIND_R2L  = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_RADDR,
      ST_DATA,
      ST_LADDR,
      ST_DONE
   } state_t;

   // Header body: dest | class | src tile | kind | req id | word count
   function automatic logic [31:0] make_header(input logic [4:0]  dest,
                                               input logic [4:0]  tile,
                                               input logic [1:0]  kind,
                                               input logic [3:0]  id,
                                               input logic [12:0] count);
      return {dest, CLASS_DMA, tile, kind, id, count};
   endfunction

endpackage

// File: rtl/lisnoc_dma_initiator_nocpkt_if.sv
// rtl/lisnoc_dma_initiator_nocpkt_if.sv - request, FIFO and NoC output signals of the DMA packetizer
interface lisnoc_dma_initiator_nocpkt_if;
   import lisnoc_dma_initiator_nocpkt_pkg::*;

   logic                  req_start;
   logic                  req_is_l2r;
   logic [REQ_SIZE_W-1:0] req_size;
   logic [31:0]           req_laddr;
   logic [31:0]           req_raddr;
   logic [4:0]            req_dest;
   logic [3:0]            req_id;
   logic [31:0]           req_data;
   logic                  req_data_valid;
   logic                  req_data_ready;
   logic [33:0]           noc_out_flit;
   logic                  noc_out_valid;
   logic                  noc_out_ready;
   logic                  busy;
   logic                  req_done;

   // Packetizer side: drives the NoC port, FIFO pop and status
   modport master (
      input  req_start, req_is_l2r, req_size, req_laddr, req_raddr, req_dest, req_id,
      input  req_data, req_data_valid, noc_out_ready,
      output req_data_ready, noc_out_flit, noc_out_valid, busy, req_done
   );

   // Environment side: request table, FIFO and NoC
   modport slave (
      output req_start, req_is_l2r, req_size, req_laddr, req_raddr, req_dest, req_id,
      output req_data, req_data_valid, noc_out_ready,
      input  req_data_ready, noc_out_flit, noc_out_valid, busy, req_done
   );

endinterface

// File: rtl/lisnoc_dma_initiator_nocpkt.sv
// rtl/lisnoc_dma_initiator_nocpkt.sv - turns an accepted DMA request into LISNoC write or read-request packets
module lisnoc_dma_initiator_nocpkt
   import lisnoc_dma_initiator_nocpkt_pkg::*;
#(
   parameter int TILEID    = 0,
   parameter int MAX_BURST = 8
) (
   input logic                          clk,
   input logic                          rst,
   lisnoc_dma_initiator_nocpkt_if.master bus
);

   localparam logic [4:0]            TILE  = 5'(TILEID);
   localparam logic [REQ_SIZE_W-1:0] MAX_W = REQ_SIZE_W'(MAX_BURST);

   state_t                state;
   logic                  l2r_q;
   logic [31:0]           laddr_q;
   logic [4:0]            dest_q;
   logic [3:0]            id_q;
   logic [REQ_SIZE_W-1:0] remaining;
   logic [REQ_SIZE_W-1:0] pkt_words;
   logic [REQ_SIZE_W-1:0] pkt_cnt;
   logic [31:0]           cur_raddr;
   logic [33:0]           flit_q;

   logic                  data_hs;
   logic                  last_word;
   logic [REQ_SIZE_W-1:0] rem_next;

   function automatic logic [REQ_SIZE_W-1:0] burst_len(input logic [REQ_SIZE_W-1:0] rem);
      return (rem > MAX_W) ? MAX_W : rem;
   endfunction

   assign data_hs   = (state == ST_DATA) && bus.req_data_valid && bus.noc_out_ready;
   assign last_word = (pkt_cnt == REQ_SIZE_W'(1));
   assign rem_next  = remaining - REQ_SIZE_W'(1);

   // Request sequencing; flit_q holds the next header/address flit ready for presentation
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         l2r_q     <= 1'b0;
         laddr_q   <= '0;
         dest_q    <= '0;
         id_q      <= '0;
         remaining <= '0;
         pkt_words <= '0;
         pkt_cnt   <= '0;
         cur_raddr <= '0;
         flit_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_start) begin
                  l2r_q     <= bus.req_is_l2r;
                  laddr_q   <= bus.req_laddr;
                  dest_q    <= bus.req_dest;
                  id_q      <= bus.req_id;
                  remaining <= bus.req_size;
                  cur_raddr <= bus.req_raddr;
                  if (bus.req_is_l2r && bus.req_size == '0) begin
                     state <= ST_DONE;
                  end else if (bus.req_is_l2r) begin
                     state     <= ST_HDR;
                     pkt_words <= burst_len(bus.req_size);
                     flit_q    <= {FLIT_HEADER, make_header(bus.req_dest, TILE, KIND_L2R, bus.req_id,
                                                            13'(burst_len(bus.req_size)))};
                  end else begin
                     state     <= ST_HDR;
                     pkt_words <= '0;
                     flit_q    <= {FLIT_HEADER, make_header(bus.req_dest, TILE, KIND_R2L, bus.req_id,
                                                            bus.req_size[12:0])};
                  end
               end
            end
            ST_HDR: begin
               if (bus.noc_out_ready) begin
                  state  <= ST_RADDR;
                  flit_q <= {FLIT_PAYLOAD, cur_raddr};
               end
            end
            ST_RADDR: begin
               if (bus.noc_out_ready) begin
                  if (l2r_q) begin
                     state   <= ST_DATA;
                     pkt_cnt <= pkt_words;
                     flit_q  <= '0;
                  end else begin
                     state  <= ST_LADDR;
                     flit_q <= {FLIT_LAST, laddr_q};
                  end
               end
            end
            ST_DATA: begin
               if (data_hs) begin
                  pkt_cnt   <= pkt_cnt - REQ_SIZE_W'(1);
                  remaining <= rem_next;
                  if (last_word) begin
                     cur_raddr <= cur_raddr + {pkt_words, 2'b00};
                     if (rem_next == '0) begin
                        state <= ST_DONE;
                     end else begin
                        state     <= ST_HDR;
                        pkt_words <= burst_len(rem_next);
                        flit_q    <= {FLIT_HEADER, make_header(dest_q, TILE, KIND_L2R, id_q,
                                                               13'(burst_len(rem_next)))};
                     end
                  end
               end
            end
            ST_LADDR: begin
               if (bus.noc_out_ready) begin
                  state  <= ST_DONE;
                  flit_q <= '0;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output steering: data flits track the FIFO head, all others come from flit_q
   always_comb begin
      bus.noc_out_valid = 1'b0;
      bus.noc_out_flit  = flit_q;
      case (state)
         ST_HDR, ST_RADDR, ST_LADDR: bus.noc_out_valid = 1'b1;
         ST_DATA: begin
            bus.noc_out_valid = bus.req_data_valid;
            bus.noc_out_flit  = {last_word ? FLIT_LAST : FLIT_PAYLOAD, bus.req_data};
         end
         default: bus.noc_out_valid = 1'b0;
      endcase
   end

   assign bus.req_data_ready = data_hs;
   assign bus.busy           = (state != ST_IDLE);
   assign bus.req_done       = (state == ST_DONE);

endmodule

// File: doc/lisnoc_dma_initiator_nocpkt.md
# lisnoc_dma_initiator_nocpkt

Consumer stage of the DMA initiator's local-read word FIFO. It turns an accepted DMA request into LISNoC packets on the initiator's outbound request channel.
- L2R (local-to-remote) requests become one or more write packets. Each packet is header, remote address, then data words popped from the FIFO.
- R2L (remote-to-local) requests become a single read-request packet.
- The block sits between the request table / control unit and the NoC output port, in parallel with the wishbone fetch stage that fills the FIFO.

## Interface
Parameters:
- TILEID, 0, source tile id placed in every header.
- MAX_BURST, 8, maximum data words per L2R packet (power of two, 1..64).

Ports (clock and reset first):
- clk  in  1  system clock; all logic is on one clock.
- rst  in  1  reset; synchronous, active-high.
- req_start  in  1  one-cycle pulse; accepts a request when the block is idle.
- req_is_l2r  in  1  1: L2R write; 0: R2L read request.
- req_size  in  `DMA_REQFIELD_SIZE_WIDTH-2  transfer length in 32-bit words.
- req_laddr  in  32  local byte address (word aligned).
- req_raddr  in  32  remote byte address (word aligned).
- req_dest  in  5  destination tile id.
- req_id  in  4  request table slot.
- req_data  in  32  FIFO head word.
- req_data_valid  in  1  FIFO non-empty.
- req_data_ready  out  1  pop strobe to FIFO.
- noc_out_flit  out  34  [33:32] type (01 header, 00 payload, 10 last), [31:0] body.
- noc_out_valid  out  1  flit valid.
- noc_out_ready  in  1  NoC accepts flit.
- busy  out  1  request in progress.
- req_done  out  1  one-cycle pulse, request fully sent.

## Operation
- Header body:
  - [31:27] dest; [26:24] class 3'b010; [23:19] TILEID.
  - [18:17] kind: 00 L2R write, 01 R2L read.
  - [16:13] req_id; [12:0] word count of this packet (L2R), or req_size truncated to 13 bits (R2L).
- On req_start in IDLE, latch all request fields. Set remaining = req_size and cur_raddr = req_raddr.
- req_start outside IDLE is ignored.
- States: IDLE, HDR, RADDR, DATA, LADDR, DONE.
  - IDLE→HDR on req_start, except: L2R with req_size==0 goes IDLE→DONE.
  - HDR→RADDR on handshake.
  - RADDR→DATA (L2R) or →LADDR (R2L) on handshake.
  - DATA: pkt_words = min(remaining, MAX_BURST), computed at HDR entry. Each accepted flit decrements pkt_cnt and remaining. After the last word of a packet: if remaining is 0 →DONE, else →HDR, and cur_raddr advances by 4·pkt_words.
  - LADDR→DONE on handshake.
  - DONE→IDLE unconditionally. req_done is high in DONE.
- Flit types:
  - L2R packets: header is 01; RADDR and non-final DATA flits are 00; the final DATA flit is 10.
  - R2L packets: HDR 01, RADDR 00, LADDR 10 (body = latched req_laddr).
- busy = state != IDLE.
- Counters are `DMA_REQFIELD_SIZE_WIDTH-2 bits wide. Address arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- Reset values: noc_out_valid 0, noc_out_flit 0, req_data_ready 0, busy 0, req_done 0. State is IDLE and all counters are 0.
- First header is valid the cycle after the req_start pulse.
- noc_out_valid:
  - In HDR, RADDR and LADDR it is 1.
  - In DATA it equals req_data_valid.
  - It never depends combinationally on noc_out_ready.
- Once valid is asserted, flit and valid stay stable until noc_out_ready, except in DATA, where valid and flit track the FIFO head (the FIFO head is stable until popped).
- req_data_ready = (state==DATA) & req_data_valid & noc_out_ready. Exactly one pop per accepted data flit; no pops in any other state.
- Throughput is one flit per cycle when the FIFO and NoC are never stalled. Per-packet overhead is 2 flits (header + address).
- With an empty FIFO in DATA, valid drops and the block waits. Packet flit order is preserved across stalls.
- rst mid-packet returns to IDLE next cycle with valid 0. The truncated packet is not completed; the system resets NoC and FIFO together.

## Structure
- Header field offsets, the class code, kind codes and flit type codes go in the shared DMA define header beside the existing request-field widths. Undefine them in the matching undef header.
- The block is a single flat module. A sub-module is not warranted.

## Test plan
- L2R, size 3, raddr 0x1000, dest 5, id 2, FIFO preloaded 0xA,0xB,0xC, ready tied 1 → flits: header (count 3), 0x1000, 0xA (00), 0xB (00), 0xC (10). req_done is pulsed in the cycle after the last flit; 3 pops.
- L2R, size 20, MAX_BURST 8 → three packets of 8, 8 and 4 words, with address flits 0x1000, 0x1020, 0x1040; exactly 20 pops.
- R2L, size 16, raddr 0x2000, laddr 0x3000 → header (kind 01, count 16), 0x2000 (00), 0x3000 (10); zero pops; done pulse.
- Random noc_out_ready and random FIFO gaps on L2R size 9 → identical flit sequence, stable flit while valid & ~ready, no pop without handshake.
- req_start pulsed while busy, and L2R size 0 → the busy request is unaffected; the size-0 request gives req_done after 2 cycles with no flits.
- rst asserted in DATA after 2 of 5 words → next cycle valid 0, busy 0, IDLE. A following size-1 request then completes normally.
